// File: rtl/mc_control_fsm_if.sv
// Control-unit bundle: instruction/status inputs from the datapath and the
// strobes and mux selects the sequencer drives back into it.
interface mc_control_fsm_if #(
  parameter int unsigned ILEN  = 16,
  parameter int unsigned CNT_W = 16
);
  logic [ILEN-1:0]  instruction;
  logic             zero_flag;
  logic             mem_ready;
  logic             mem_req;
  logic             pc_write;
  logic             adr_src;
  logic             mem_wr;
  logic             ir_wr;
  logic             reg_wr;
  logic [1:0]       result_src;
  logic [2:0]       alu_control;
  logic [1:0]       alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       imm_src;
  logic [3:0]       state;
  logic             illegal;
  logic [CNT_W-1:0] retired;

  modport master (
    input  instruction, zero_flag, mem_ready,
    output mem_req, pc_write, adr_src, mem_wr, ir_wr, reg_wr, result_src, alu_control,
           alu_src_a, alu_src_b, imm_src, state, illegal, retired
  );

  modport slave (
    output instruction, zero_flag, mem_ready,
    input  mem_req, pc_write, adr_src, mem_wr, ir_wr, reg_wr, result_src, alu_control,
           alu_src_a, alu_src_b, imm_src, state, illegal, retired
  );
endinterface

// File: rtl/mc_control_fsm.sv
// Multicycle sequencer for the 16-bit core: fetch/decode/execute with a
// variable-latency memory handshake, branches, sticky trap and retire counter.
module mc_control_fsm #(
  parameter int unsigned ILEN   = 16,
  parameter int unsigned F3_LSB = 13,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned EN_JAL = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  mc_control_fsm_if.master   bus
);

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecR    = 4'd6,
    StAluWb    = 4'd7,
    StExecI    = 4'd8,
    StBranch   = 4'd9,
    StJump     = 4'd10,
    StTrap     = 4'd11
  } state_e;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;

  state_e           state_q, state_d;
  logic             illegal_q;
  logic [CNT_W-1:0] retired_q;
  logic             retire;

  logic [1:0] op;
  logic [2:0] func3;
  logic       is_jal;

  assign op     = bus.instruction[1:0];
  assign func3  = bus.instruction[F3_LSB+2:F3_LSB];
  assign is_jal = (op == 2'b11) && (func3 == 3'b101) && (EN_JAL != 0);

  // Only op and func3 are decoded; the rest of the word belongs to the datapath.
  logic unused_instr;
  assign unused_instr = ^bus.instruction;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StFetch;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_d == StTrap) illegal_q <= 1'b1;
      if (retire) retired_q <= retired_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      StFetch:    if (bus.mem_ready) state_d = StDecode;
      StDecode: begin
        unique case (op)
          2'b00, 2'b01: state_d = StMemAdr;
          2'b10:        state_d = StExecR;
          default: begin
            case (func3)
              3'b111, 3'b110: state_d = StBranch;
              3'b101:         state_d = (EN_JAL != 0) ? StJump : StTrap;
              3'b100:         state_d = StTrap;
              default:        state_d = StExecI;
            endcase
          end
        endcase
      end
      StMemAdr:   state_d = (op == 2'b01) ? StMemWrite : StMemRead;
      StMemRead:  if (bus.mem_ready) state_d = StMemWb;
      StMemWrite: begin
        if (bus.mem_ready) begin
          state_d = StFetch;
          retire  = 1'b1;
        end
      end
      StExecR, StExecI: state_d = StAluWb;
      StMemWb, StAluWb, StBranch, StJump: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      StTrap:     state_d = StTrap;
      default:    state_d = StFetch;
    endcase
  end

  always_comb begin
    bus.mem_req     = 1'b0;
    bus.pc_write    = 1'b0;
    bus.adr_src     = 1'b0;
    bus.mem_wr      = 1'b0;
    bus.ir_wr       = 1'b0;
    bus.reg_wr      = 1'b0;
    bus.result_src  = 2'b00;
    bus.alu_control = AluAdd;
    bus.alu_src_a   = 2'b00;
    bus.alu_src_b   = 2'b00;
    bus.imm_src     = 2'b00;
    case (state_q)
      StFetch: begin
        bus.mem_req   = 1'b1;
        bus.alu_src_b = 2'b10;
        bus.ir_wr     = bus.mem_ready;
        bus.pc_write  = bus.mem_ready;
      end
      StDecode: begin
        // Branch/jump target is precomputed here from oldPC + imm.
        bus.alu_src_a = 2'b01;
        bus.alu_src_b = 2'b01;
        bus.imm_src   = is_jal ? 2'b11 : 2'b10;
      end
      StMemAdr: begin
        bus.alu_src_a = 2'b10;
        bus.alu_src_b = 2'b01;
        bus.imm_src   = (op == 2'b01) ? 2'b01 : 2'b00;
      end
      StMemRead: begin
        bus.mem_req = 1'b1;
        bus.adr_src = 1'b1;
      end
      StMemWb: begin
        bus.result_src = 2'b01;
        bus.reg_wr     = 1'b1;
      end
      StMemWrite: begin
        bus.mem_req = 1'b1;
        bus.mem_wr  = 1'b1;
        bus.adr_src = 1'b1;
      end
      StExecR: begin
        bus.alu_src_a   = 2'b10;
        bus.alu_control = func3;
      end
      StExecI: begin
        bus.alu_src_a   = 2'b10;
        bus.alu_src_b   = 2'b01;
        bus.alu_control = func3;
      end
      StAluWb: bus.reg_wr = 1'b1;
      StBranch: begin
        bus.alu_src_a   = 2'b10;
        bus.alu_src_b   = 2'b11;
        bus.alu_control = AluSub;
        bus.pc_write    = (func3 == 3'b111) ? !bus.zero_flag : bus.zero_flag;
      end
      StJump:  bus.pc_write = 1'b1;
      default: ;
    endcase
  end

  assign bus.state   = state_q;
  assign bus.illegal = illegal_q;
  assign bus.retired = retired_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: per-instruction phase model with random latencies,
// random zero flag and random instructions, compared every cycle.
module tb_mc_control_fsm;

  localparam int unsigned CntW = 4;

  logic clk;
  logic rst_n;
  int unsigned n_cmp;
  int unsigned n_err;
  int unsigned done_cnt;
  logic [15:0] cur_instr;

  mc_control_fsm_if #(.ILEN(16), .CNT_W(CntW)) bus ();

  mc_control_fsm #(
    .ILEN(16),
    .F3_LSB(13),
    .CNT_W(CntW),
    .EN_JAL(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [15:0] mk(input logic [1:0] op, input logic [2:0] f3);
    logic [10:0] mid;
    mid = 11'($urandom);
    return {f3, mid, op};
  endfunction

  // {mem_req, pc_write, adr_src, mem_wr, ir_wr, reg_wr, result_src, alu_control,
  //  alu_src_a, alu_src_b, imm_src}
  function automatic logic [16:0] outs_now();
    return {bus.mem_req, bus.pc_write, bus.adr_src, bus.mem_wr, bus.ir_wr, bus.reg_wr,
            bus.result_src, bus.alu_control, bus.alu_src_a, bus.alu_src_b, bus.imm_src};
  endfunction

  function automatic logic [16:0] exp_outs(input int st, input logic [1:0] op,
                                           input logic [2:0] f3, input logic rdy,
                                           input logic z);
    logic mreq, pcw, adr, mwr, irw, rw;
    logic [1:0] rs, sa, sb, imm;
    logic [2:0] alu;
    {mreq, pcw, adr, mwr, irw, rw} = '0;
    rs = 0; sa = 0; sb = 0; imm = 0; alu = 3'd0;
    case (st)
      0:  begin mreq = 1; pcw = rdy; irw = rdy; sb = 2; end
      1:  begin sa = 1; sb = 1; imm = (op == 3 && f3 == 5) ? 2'd3 : 2'd2; end
      2:  begin sa = 2; sb = 1; imm = (op == 1) ? 2'd1 : 2'd0; end
      3:  begin mreq = 1; adr = 1; end
      4:  begin rs = 1; rw = 1; end
      5:  begin mreq = 1; mwr = 1; adr = 1; end
      6:  begin sa = 2; sb = 0; alu = f3; end
      7:  rw = 1;
      8:  begin sa = 2; sb = 1; alu = f3; end
      9:  begin sa = 2; sb = 3; alu = 3'd1; pcw = (f3 == 7) ? !z : z; end
      10: pcw = 1;
      default: ;
    endcase
    return {mreq, pcw, adr, mwr, irw, rw, rs, alu, sa, sb, imm};
  endfunction

  // One clock: drive inputs just after the falling edge, compare, wait for next fall.
  task automatic step(input int st, input logic rdy, input int zmode);
    logic z;
    z = (zmode == 2) ? rb() : 1'(zmode);
    bus.mem_ready = rdy;
    bus.zero_flag = z;
    #1;
    check_eq("state", 32'(bus.state), 32'(st));
    check_eq("outs", 32'(outs_now()),
             32'(exp_outs(st, cur_instr[1:0], cur_instr[15:13], rdy, z)));
    check_eq("illegal", 32'(bus.illegal), 32'(st == 11));
    check_eq("retired", 32'(bus.retired), done_cnt % (1 << CntW));
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check_eq("rst_state", 32'(bus.state), 32'd0);
    check_eq("rst_retired", 32'(bus.retired), 32'd0);
    check_eq("rst_illegal", 32'(bus.illegal), 32'd0);
    check_eq("rst_fetch_strobes", 32'({bus.mem_req, bus.ir_wr, bus.pc_write}), 32'b111);
    done_cnt = 0;
    rst_n = 1'b1;
  endtask

  task automatic run_instr(input logic [15:0] instr, input int wf, input int wm, input int zm);
    logic [1:0] op;
    logic [2:0] f3;
    logic trapped;
    trapped = 1'b0;
    cur_instr = instr;
    bus.instruction = instr;
    op = instr[1:0];
    f3 = instr[15:13];
    repeat (wf) step(0, 1'b0, zm);
    step(0, 1'b1, zm);
    step(1, rb(), zm);
    case (op)
      2'd0: begin
        step(2, rb(), zm);
        repeat (wm) step(3, 1'b0, zm);
        step(3, 1'b1, zm);
        step(4, rb(), zm);
      end
      2'd1: begin
        step(2, rb(), zm);
        repeat (wm) step(5, 1'b0, zm);
        step(5, 1'b1, zm);
      end
      2'd2: begin
        step(6, rb(), zm);
        step(7, rb(), zm);
      end
      default: begin
        if (f3 == 7 || f3 == 6) step(9, rb(), zm);
        else if (f3 == 5) step(10, rb(), zm);
        else if (f3 == 4) begin
          repeat (20) step(11, rb(), zm);
          trapped = 1'b1;
          do_reset();
        end else begin
          step(8, rb(), zm);
          step(7, rb(), zm);
        end
      end
    endcase
    if (!trapped) done_cnt++;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    done_cnt = 0;
    cur_instr = '0;
    bus.instruction = '0;
    bus.zero_flag = 1'b0;
    bus.mem_ready = 1'b1;
    rst_n = 1'b0;
    do_reset();

    run_instr(mk(2'b10, 3'b010), 0, 0, 2);
    run_instr(mk(2'b00, 3'b000), 3, 3, 2);
    run_instr(mk(2'b11, 3'b111), 0, 0, 0);
    run_instr(mk(2'b11, 3'b111), 0, 0, 1);
    run_instr(mk(2'b11, 3'b110), 0, 0, 0);
    run_instr(mk(2'b11, 3'b110), 0, 0, 1);
    run_instr(mk(2'b01, 3'b000), 2, 2, 2);
    run_instr(mk(2'b11, 3'b101), 1, 0, 2);
    run_instr(mk(2'b11, 3'b100), 0, 0, 2);

    for (int i = 0; i < 17; i++) run_instr(mk(2'b10, 3'($urandom)), 0, 0, 2);
    #1;
    check_eq("retired_wrap", 32'(bus.retired), 32'd1);

    for (int i = 0; i < 300; i++) begin
      run_instr(16'($urandom), $urandom_range(0, 3), $urandom_range(0, 4), 2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
